// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator opcode builder.
// Key buffering is enabled by defining CALC_KEY_BUFFER_EN.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GOT_A,
        GOT_OP,
        SEND
    } state_t;

    localparam logic [1:0] SEL_ADD = 2'd0;
    localparam logic [1:0] SEL_SUB = 2'd1;
    localparam logic [1:0] SEL_OR  = 2'd2;
    localparam logic [1:0] SEL_NEG = 2'd3;

    localparam logic [3:0] CLR_CODE_DEF = 4'hF;

    localparam int OPC_W      = 14;
    localparam int OPC_SEL_HI = 13;
    localparam int OPC_SEL_LO = 12;
    localparam int OPC_A_HI   = 11;
    localparam int OPC_A_LO   = 8;
    localparam int OPC_B_HI   = 7;
    localparam int OPC_B_LO   = 4;

    function automatic logic [OPC_W-1:0] pack_opcode(
        input logic [1:0] sel,
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic [OPC_W-1:0] w;
        w = '0;
        w[OPC_SEL_HI:OPC_SEL_LO] = sel;
        w[OPC_A_HI:OPC_A_LO]     = a;
        w[OPC_B_HI:OPC_B_LO]     = b;
        return w;
    endfunction

endpackage

// File: rtl/calc_key_fifo.sv
// Two-entry key FIFO ({is_op, data}) with registered output and no bypass.
// Used only when CALC_KEY_BUFFER_EN is defined.
module calc_key_fifo (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic [4:0] i_din,
    input  logic       i_pop,
    output logic [4:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);

    logic [4:0] r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/calc_opcode_builder.sv
// Key-event FSM assembling 14-bit calculator opcodes on a valid/ready port.
// Define CALC_KEY_BUFFER_EN to insert a 2-entry key FIFO ahead of the FSM.
module calc_opcode_builder
    import calc_pkg::*;
#(
    parameter logic [3:0] CLR_CODE = CLR_CODE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic             key_is_op,
    input  logic [3:0]       key_data,
    output logic             key_ready,
    output logic [OPC_W-1:0] opcode,
    output logic             opcode_valid,
    input  logic             opcode_ready,
    output logic             err
);

    state_t     r_state, w_state_nx;
    logic [1:0] r_sel, w_sel_nx;
    logic [3:0] r_a, w_a_nx;
    logic [3:0] r_b, w_b_nx;
    logic       r_err, w_err_nx;

    logic       w_kv;
    logic       w_op;
    logic [3:0] w_kd;
    logic       w_is_clr;
    logic       w_is_sel;
    logic       w_is_bad;

`ifdef CALC_KEY_BUFFER_EN
    logic       w_full;
    logic       w_empty;
    logic [4:0] w_head;

    calc_key_fifo u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (key_valid && !w_full),
        .i_din   ({key_is_op, key_data}),
        .i_pop   (w_kv),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Queued keys wait while a word is pending so a clear cannot cancel it.
    assign w_kv        = !w_empty && (r_state != SEND);
    assign {w_op, w_kd} = w_head;
    assign key_ready   = !w_full;
`else
    assign key_ready = (r_state != SEND);
    assign w_kv      = key_valid && key_ready;
    assign w_op      = key_is_op;
    assign w_kd      = key_data;
`endif

    assign w_is_clr = w_op && (w_kd == CLR_CODE);
    assign w_is_sel = w_op && !w_is_clr && (w_kd[3:2] == 2'b00);
    assign w_is_bad = w_op && !w_is_clr && !w_is_sel;

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_err_nx   = 1'b0;
        if (r_state == SEND) begin
            if (opcode_ready) begin
                w_state_nx = IDLE;
            end
        end else if (w_kv) begin
            unique case (1'b1)
                w_is_bad: w_err_nx = 1'b1;
                w_is_clr: w_state_nx = IDLE;
                !w_op: begin
                    unique case (r_state)
                        IDLE: begin
                            w_a_nx     = w_kd;
                            w_state_nx = GOT_A;
                        end
                        GOT_A: w_a_nx = w_kd;
                        default: begin
                            w_b_nx     = w_kd;
                            w_state_nx = SEND;
                        end
                    endcase
                end
                default: begin
                    if (r_state == IDLE) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_sel_nx = w_kd[1:0];
                        unique case (w_kd[1:0])
                            SEL_ADD, SEL_SUB, SEL_OR: w_state_nx = GOT_OP;
                            SEL_NEG: begin
                                w_b_nx     = 4'h0;
                                w_state_nx = SEND;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_a     <= 4'h0;
            r_b     <= 4'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_err   <= w_err_nx;
        end
    end

    assign opcode       = pack_opcode(r_sel, r_a, r_b);
    assign opcode_valid = (r_state == SEND);
    assign err          = r_err;

endmodule

// File: tb/tb_calc_opcode_builder.sv
// Directed bench for calc_opcode_builder with a key-level reference model.
// Follows CALC_KEY_BUFFER_EN to choose buffered or direct timing.
module tb_calc_opcode_builder;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic        key_is_op;
    logic [3:0]  key_data;
    logic        key_ready;
    logic [13:0] opcode;
    logic        opcode_valid;
    logic        opcode_ready;
    logic        err;

    int checks;
    int failures;
    bit cmp_en;

    calc_opcode_builder dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_is_op    (key_is_op),
        .key_data     (key_data),
        .key_ready    (key_ready),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .opcode_ready (opcode_ready),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    // Reference model: keys collected so far, and whether a word waits.
    logic [4:0] m_q[$];
    int         m_have;
    bit         m_pend;
    bit         m_err;
    logic [1:0] m_sel;
    logic [3:0] m_a;
    logic [3:0] m_b;

    function automatic bit exp_ready();
`ifdef CALC_KEY_BUFFER_EN
        return m_q.size() < 2;
`else
        return !m_pend;
`endif
    endfunction

    always @(posedge clk) begin
        logic [4:0] k;
        bit         has;
        bit         take;
        if (rst) begin
            m_q.delete();
            m_have = 0;
            m_pend = 0;
            m_err  = 0;
            m_sel  = 0;
            m_a    = 0;
            m_b    = 0;
        end else begin
            take = key_valid && exp_ready();
            k    = {key_is_op, key_data};
`ifdef CALC_KEY_BUFFER_EN
            has = (m_q.size() > 0) && !m_pend;
            if (has) k = m_q.pop_front();
            if (take) m_q.push_back({key_is_op, key_data});
`else
            has = take && !m_pend;
`endif
            m_err = 0;
            if (m_pend && opcode_ready) m_pend = 0;
            if (has) begin
                if (k[4] && k[3:0] == 4'hF) begin
                    m_have = 0;
                end else if (k[4] && k[3:0] > 4'd3) begin
                    m_err = 1;
                end else if (!k[4]) begin
                    if (m_have == 2) begin
                        m_b    = k[3:0];
                        m_pend = 1;
                        m_have = 0;
                    end else begin
                        m_a    = k[3:0];
                        m_have = 1;
                    end
                end else if (m_have == 0) begin
                    m_err = 1;
                end else begin
                    m_sel = k[1:0];
                    if (k[1:0] == 2'd3) begin
                        m_b    = 0;
                        m_pend = 1;
                        m_have = 0;
                    end else begin
                        m_have = 2;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_valid", opcode_valid, m_pend);
            chk("cyc_key_ready", key_ready, exp_ready());
            chk("cyc_err", err, m_err);
            if (m_pend) chk("cyc_opcode", opcode, {m_sel, m_a, m_b, 4'h0});
        end
    end

    task automatic send_key(input bit op, input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_is_op = op;
        key_data  = d;
        while (!key_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("send_timeout", 1, 0);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic expect_word(input string n, input logic [13:0] w);
`ifdef CALC_KEY_BUFFER_EN
        chk({n, "_early"}, opcode_valid, 0);
        @(negedge clk);
`endif
        chk({n, "_valid"}, opcode_valid, 1);
        chk({n, "_word"}, opcode, w);
    endtask

    task automatic expect_err(input string n);
`ifdef CALC_KEY_BUFFER_EN
        chk({n, "_early"}, err, 0);
        @(negedge clk);
`endif
        chk(n, err, 1);
    endtask

    task automatic handshake(input string n);
        opcode_ready = 1'b1;
        @(negedge clk);
        opcode_ready = 1'b0;
        chk({n, "_drop"}, opcode_valid, 0);
    endtask

    task automatic wait_valid(input string n, input int budget);
        int c;
        c = 0;
        while (!opcode_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) chk({n, "_timeout"}, 1, 0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cmp_en       = 0;
        rst          = 1'b1;
        key_valid    = 1'b0;
        key_is_op    = 1'b0;
        key_data     = 4'h0;
        opcode_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_opcode", opcode, 14'h0000);
        chk("rst_valid", opcode_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_key_ready", key_ready, 1);
        rst    = 1'b0;
        cmp_en = 1;

        send_key(0, 4'd5);
        send_key(1, 4'd0);
        send_key(0, 4'd3);
        expect_word("add53", 14'h0530);
        @(negedge clk);
        handshake("add53");

        send_key(0, 4'd7);
        send_key(1, 4'd3);
        expect_word("neg7", 14'h3700);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("neg7_hold", opcode, 14'h3700);
`ifdef CALC_KEY_BUFFER_EN
            chk("neg7_kr_hold", key_ready, 1);
`else
            chk("neg7_kr_hold", key_ready, 0);
`endif
        end
`ifdef CALC_KEY_BUFFER_EN
        send_key(0, 4'd9);
        chk("buf_one", key_ready, 1);
        send_key(1, 4'd3);
        chk("buf_full", key_ready, 0);
        chk("buf_pending", opcode, 14'h3700);
        handshake("neg7");
        wait_valid("neg9", 10);
        chk("neg9_word", opcode, 14'h3900);
        @(negedge clk);
        handshake("neg9");
`else
        handshake("neg7");
`endif

        send_key(1, 4'd1);
        expect_err("err_idle_op");
        send_key(0, 4'd2);
        send_key(1, 4'd9);
        expect_err("err_illegal");

        send_key(0, 4'd4);
        send_key(1, 4'd1);
        send_key(1, 4'd2);
        send_key(0, 4'd1);
        expect_word("or41", 14'h2410);
        handshake("or41");

        send_key(0, 4'd8);
        send_key(1, 4'hF);
        repeat (3) @(negedge clk);
        chk("clr_no_word", opcode_valid, 0);

        send_key(0, 4'd6);
        send_key(1, 4'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_opcode", opcode, 14'h0000);
        chk("mid_rst_valid", opcode_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_key_ready", key_ready, 1);
        rst = 1'b0;

        send_key(0, 4'd1);
        send_key(1, 4'd0);
        send_key(0, 4'd1);
        expect_word("add11", 14'h0110);
        handshake("add11");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
